// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-back arbiter and its scoreboard.
package regfile_wb_arbiter_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic {
    A_PRIO  = 1'b0,
    B_FORCE = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   dat;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// wb_scoreboard: pending-write bit per register, set on issue, cleared on write-back, two lookups.
// Bit 0 (x0) never becomes pending; a same-cycle set and clear of one bit leaves it set.
module wb_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [AW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_idx,
  input  logic [AW-1:0] q1_idx,
  input  logic [AW-1:0] q2_idx,
  output logic          q1_pending,
  output logic          q2_pending
);

  logic [NREG-1:0] pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (set_en && set_idx == AW'(i)) pending[i] <= 1'b1;
        else if (clr_en && clr_idx == AW'(i)) pending[i] <= 1'b0;
      end
    end
  end

  assign q1_pending = pending[q1_idx];
  assign q2_pending = pending[q2_idx];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU (A) and LSU (B) results onto the single register-file write port, with B starvation guard.
// Optional macro REGFILE_WB_BYPASS_EN adds forwarding outputs for the write in the output stage.
module regfile_wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [4:0]      a_rd,
  input  logic [XLEN-1:0] a_dat,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [4:0]      b_rd,
  input  logic [XLEN-1:0] b_dat,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            busy_rs1,
  output logic            busy_rs2,
  output logic            wen,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] rd_dat
`ifdef REGFILE_WB_BYPASS_EN
  ,
  output logic            fwd1_hit,
  output logic            fwd2_hit,
  output logic [XLEN-1:0] fwd1_dat,
  output logic [XLEN-1:0] fwd2_dat
`endif
);

  import regfile_wb_arbiter_pkg::*;

  localparam int CW = $clog2(STARVE_MAX + 1);

  arb_state_e    state;
  logic [CW-1:0] starve_cnt;
  logic [CW-1:0] starve_nxt;
  logic          a_grant;
  logic          b_grant;
  wb_req_t       sel;
  logic          pend1;
  logic          pend2;

  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (!rst) begin
      if (state == B_FORCE) begin
        b_ready = b_valid;
      end else begin
        a_ready = a_valid;
        b_ready = b_valid && !a_valid;
      end
    end
  end

  assign a_grant = a_valid && a_ready;
  assign b_grant = b_valid && b_ready;

  always_comb begin
    sel.rd  = a_rd;
    sel.dat = a_dat;
    if (b_grant) begin
      sel.rd  = b_rd;
      sel.dat = b_dat;
    end
  end

  always_comb begin
    if (!b_valid || b_grant)                 starve_nxt = '0;
    else if (starve_cnt == CW'(STARVE_MAX))  starve_nxt = starve_cnt;
    else                                     starve_nxt = starve_cnt + 1'b1;
  end

  // Forcing on the next count lets B win in the cycle right after its STARVE_MAX-th wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= A_PRIO;
      starve_cnt <= '0;
      wen        <= 1'b0;
      rd         <= '0;
      rd_dat     <= '0;
    end else begin
      starve_cnt <= starve_nxt;
      case (state)
        A_PRIO:  if (starve_nxt == CW'(STARVE_MAX)) state <= B_FORCE;
        B_FORCE: if (b_grant || !b_valid) state <= A_PRIO;
        default: state <= A_PRIO;
      endcase
      wen <= (a_grant || b_grant) && (sel.rd != '0);
      if (a_grant || b_grant) begin
        rd     <= sel.rd;
        rd_dat <= sel.dat;
      end
    end
  end

  wb_scoreboard #(.NREG(NREG), .AW(5)) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_en     (issue_valid && issue_rd != '0),
    .set_idx    (issue_rd),
    .clr_en     (b_grant),
    .clr_idx    (b_rd),
    .q1_idx     (rs1),
    .q2_idx     (rs2),
    .q1_pending (pend1),
    .q2_pending (pend2)
  );

`ifdef REGFILE_WB_BYPASS_EN
  assign busy_rs1 = (rs1 != '0) && pend1;
  assign busy_rs2 = (rs2 != '0) && pend2;
  assign fwd1_hit = wen && (rd == rs1) && (rs1 != '0);
  assign fwd2_hit = wen && (rd == rs2) && (rs2 != '0);
  assign fwd1_dat = rd_dat;
  assign fwd2_dat = rd_dat;
`else
  // The output-stage write is not yet visible to the register file's combinational read.
  assign busy_rs1 = (rs1 != '0) && (pend1 || (wen && rd == rs1));
  assign busy_rs2 = (rs2 != '0) && (pend2 || (wen && rd == rs2));
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed table-driven bench for regfile_wb_arbiter plus hand sequences for reset, starvation and bypass.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, issue_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_rd, b_rd, issue_rd, rs1, rs2, rd;
  logic [31:0] a_dat, b_dat, rd_dat;
  logic        busy_rs1, busy_rs2, wen;
`ifdef REGFILE_WB_BYPASS_EN
  logic        fwd1_hit, fwd2_hit;
  logic [31:0] fwd1_dat, fwd2_dat;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_dat(a_dat),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_dat(b_dat),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2), .busy_rs1(busy_rs1), .busy_rs2(busy_rs2),
    .wen(wen), .rd(rd), .rd_dat(rd_dat)
`ifdef REGFILE_WB_BYPASS_EN
    , .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_dat(fwd1_dat), .fwd2_dat(fwd2_dat)
`endif
  );

  // p = pending-bit term, f = output-stage term, both expected before the clock edge
  typedef struct {
    logic av; logic [4:0] ard; logic [31:0] adat;
    logic bv; logic [4:0] brd; logic [31:0] bdat;
    logic iv; logic [4:0] ird;
    logic [4:0] r1; logic [4:0] r2;
    logic xar; logic xbr;
    logic p1; logic f1; logic p2; logic f2;
    logic xwen; logic [4:0] xrd; logic [31:0] xdat; logic chkd;
  } vec_t;

  vec_t tv[19];

  function automatic vec_t mk(
    logic av, logic [4:0] ard, logic [31:0] adat,
    logic bv, logic [4:0] brd, logic [31:0] bdat,
    logic iv, logic [4:0] ird, logic [4:0] r1, logic [4:0] r2,
    logic xar, logic xbr, logic p1, logic f1, logic p2, logic f2,
    logic xwen, logic [4:0] xrd, logic [31:0] xdat, logic chkd);
    vec_t v;
    v.av = av; v.ard = ard; v.adat = adat;
    v.bv = bv; v.brd = brd; v.bdat = bdat;
    v.iv = iv; v.ird = ird; v.r1 = r1; v.r2 = r2;
    v.xar = xar; v.xbr = xbr; v.p1 = p1; v.f1 = f1; v.p2 = p2; v.f2 = f2;
    v.xwen = xwen; v.xrd = xrd; v.xdat = xdat; v.chkd = chkd;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    a_valid = 0; a_rd = 0; a_dat = 0;
    b_valid = 0; b_rd = 0; b_dat = 0;
    issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_row(int i, vec_t v, logic [31:0] prev_dat);
    a_valid = v.av; a_rd = v.ard; a_dat = v.adat;
    b_valid = v.bv; b_rd = v.brd; b_dat = v.bdat;
    issue_valid = v.iv; issue_rd = v.ird; rs1 = v.r1; rs2 = v.r2;
    #1;
    chk($sformatf("r%0d_a_ready", i), {31'd0, a_ready}, {31'd0, v.xar});
    chk($sformatf("r%0d_b_ready", i), {31'd0, b_ready}, {31'd0, v.xbr});
`ifdef REGFILE_WB_BYPASS_EN
    chk($sformatf("r%0d_busy_rs1", i), {31'd0, busy_rs1}, {31'd0, v.p1});
    chk($sformatf("r%0d_busy_rs2", i), {31'd0, busy_rs2}, {31'd0, v.p2});
    chk($sformatf("r%0d_fwd1_hit", i), {31'd0, fwd1_hit}, {31'd0, v.f1});
    chk($sformatf("r%0d_fwd2_hit", i), {31'd0, fwd2_hit}, {31'd0, v.f2});
    if (v.f1) chk($sformatf("r%0d_fwd1_dat", i), fwd1_dat, prev_dat);
    if (v.f2) chk($sformatf("r%0d_fwd2_dat", i), fwd2_dat, prev_dat);
`else
    chk($sformatf("r%0d_busy_rs1", i), {31'd0, busy_rs1}, {31'd0, v.p1 | v.f1});
    chk($sformatf("r%0d_busy_rs2", i), {31'd0, busy_rs2}, {31'd0, v.p2 | v.f2});
    if (prev_dat == 32'hFFFF_FFFF) n_cmp = n_cmp + 0;
`endif
    step();
    chk($sformatf("r%0d_wen", i), {31'd0, wen}, {31'd0, v.xwen});
    if (v.chkd) begin
      chk($sformatf("r%0d_rd", i), {27'd0, rd}, {27'd0, v.xrd});
      chk($sformatf("r%0d_rd_dat", i), rd_dat, v.xdat);
    end
  endtask

  initial begin
    logic [31:0] prev;

    //           a: v rd dat        b: v rd dat        iss    r1 r2  ar br p1 f1 p2 f2  wen rd dat       chkd
    tv[0]  = mk(1, 3, 32'h11,      0, 0, 0,           0, 0,  3, 0,  1, 0, 0, 0, 0, 0,  1, 3, 32'h11,   1);
    tv[1]  = mk(1, 1, 32'h101,     1, 2, 32'h202,     0, 0,  3, 0,  1, 0, 0, 1, 0, 0,  1, 1, 32'h101,  1);
    tv[2]  = mk(0, 0, 0,           1, 2, 32'h202,     0, 0,  1, 2,  0, 1, 0, 1, 0, 0,  1, 2, 32'h202,  1);
    tv[3]  = mk(0, 0, 0,           0, 0, 0,           0, 0,  2, 1,  0, 0, 0, 1, 0, 0,  0, 2, 32'h202,  1);
    tv[4]  = mk(0, 0, 0,           0, 0, 0,           1, 7,  7, 2,  0, 0, 0, 0, 0, 0,  0, 2, 32'h202,  1);
    tv[5]  = mk(0, 0, 0,           0, 0, 0,           0, 0,  7, 0,  0, 0, 1, 0, 0, 0,  0, 2, 32'h202,  1);
    tv[6]  = mk(0, 0, 0,           1, 7, 32'h77,      0, 0,  7, 0,  0, 1, 1, 0, 0, 0,  1, 7, 32'h77,   1);
    tv[7]  = mk(0, 0, 0,           0, 0, 0,           0, 0,  7, 7,  0, 0, 0, 1, 0, 1,  0, 7, 32'h77,   1);
    tv[8]  = mk(0, 0, 0,           0, 0, 0,           1, 7,  7, 0,  0, 0, 0, 0, 0, 0,  0, 7, 32'h77,   1);
    tv[9]  = mk(0, 0, 0,           1, 7, 32'h78,      1, 7,  7, 0,  0, 1, 1, 0, 0, 0,  1, 7, 32'h78,   1);
    tv[10] = mk(0, 0, 0,           0, 0, 0,           0, 0,  7, 7,  0, 0, 1, 1, 1, 1,  0, 7, 32'h78,   1);
    tv[11] = mk(0, 0, 0,           0, 0, 0,           0, 0,  7, 0,  0, 0, 1, 0, 0, 0,  0, 7, 32'h78,   1);
    tv[12] = mk(0, 0, 0,           1, 7, 32'h79,      0, 0,  7, 0,  0, 1, 1, 0, 0, 0,  1, 7, 32'h79,   1);
    tv[13] = mk(0, 0, 0,           0, 0, 0,           0, 0,  7, 0,  0, 0, 0, 1, 0, 0,  0, 7, 32'h79,   1);
    tv[14] = mk(0, 0, 0,           0, 0, 0,           0, 0,  7, 0,  0, 0, 0, 0, 0, 0,  0, 7, 32'h79,   1);
    tv[15] = mk(1, 0, 32'hFFFF_FFFF, 0, 0, 0,         1, 0,  0, 0,  1, 0, 0, 0, 0, 0,  0, 0, 0,        0);
    tv[16] = mk(0, 0, 0,           0, 0, 0,           0, 0,  0, 7,  0, 0, 0, 0, 0, 0,  0, 0, 0,        0);
    tv[17] = mk(0, 0, 0,           1, 5, 32'h55,      0, 0,  5, 6,  0, 1, 0, 0, 0, 0,  1, 5, 32'h55,   1);
    tv[18] = mk(0, 0, 0,           0, 0, 0,           0, 0,  5, 6,  0, 0, 0, 1, 0, 0,  0, 5, 32'h55,   1);

    idle_inputs();
    rst = 1;
    a_valid = 1;
    #2;
    chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
    chk("rst_wen", {31'd0, wen}, 32'd0);
    chk("rst_rd", {27'd0, rd}, 32'd0);
    chk("rst_rd_dat", rd_dat, 32'd0);
    a_valid = 0;
    step();
    rst = 0;

    // mid-operation reset: output-stage write in flight and x5 pending
    a_valid = 1; a_rd = 4; a_dat = 32'h44; issue_valid = 1; issue_rd = 5;
    step();
    idle_inputs();
    rs1 = 5;
    chk("mid_wen_before", {31'd0, wen}, 32'd1);
    chk("mid_rd_before", {27'd0, rd}, 32'd4);
    #1;
    chk("mid_busy5_before", {31'd0, busy_rs1}, 32'd1);
    rst = 1;
    a_valid = 1;
    #1;
    chk("mid_wen_after", {31'd0, wen}, 32'd0);
    chk("mid_rd_after", {27'd0, rd}, 32'd0);
    chk("mid_rd_dat_after", rd_dat, 32'd0);
    chk("mid_busy5_after", {31'd0, busy_rs1}, 32'd0);
    chk("mid_a_ready_rst", {31'd0, a_ready}, 32'd0);
    a_valid = 0;
    #1;
    rst = 0;

    prev = 32'd0;
    for (int i = 0; i < 19; i++) begin
      run_row(i, tv[i], prev);
      prev = tv[i].xdat;
    end

    // starvation: A held busy, B must win on the fifth cycle
    a_valid = 1; a_rd = 10; b_valid = 1; b_rd = 11; b_dat = 32'hBB;
    for (int k = 0; k < 4; k++) begin
      a_dat = 32'hA0 + k;
      #1;
      chk($sformatf("starve%0d_a_ready", k), {31'd0, a_ready}, 32'd1);
      chk($sformatf("starve%0d_b_ready", k), {31'd0, b_ready}, 32'd0);
      step();
      chk($sformatf("starve%0d_rd", k), {27'd0, rd}, 32'd10);
      chk($sformatf("starve%0d_rd_dat", k), rd_dat, 32'hA0 + k);
    end
    #1;
    chk("force_a_ready", {31'd0, a_ready}, 32'd0);
    chk("force_b_ready", {31'd0, b_ready}, 32'd1);
    step();
    chk("force_wen", {31'd0, wen}, 32'd1);
    chk("force_rd", {27'd0, rd}, 32'd11);
    chk("force_rd_dat", rd_dat, 32'hBB);
    b_dat = 32'hBC; a_dat = 32'hA9;
    #1;
    chk("resume_a_ready", {31'd0, a_ready}, 32'd1);
    chk("resume_b_ready", {31'd0, b_ready}, 32'd0);
    step();
    chk("resume_rd", {27'd0, rd}, 32'd10);
    chk("resume_rd_dat", rd_dat, 32'hA9);
    idle_inputs();
    step();
    chk("idle_wen", {31'd0, wen}, 32'd0);
    chk("idle_rd_hold", {27'd0, rd}, 32'd10);

`ifdef REGFILE_WB_BYPASS_EN
    a_valid = 1; a_rd = 9; a_dat = 32'hABCD;
    step();
    idle_inputs();
    rs2 = 9;
    #1;
    chk("byp_fwd2_hit", {31'd0, fwd2_hit}, 32'd1);
    chk("byp_fwd2_dat", fwd2_dat, 32'hABCD);
    chk("byp_busy_rs2", {31'd0, busy_rs2}, 32'd0);
    chk("byp_fwd1_hit", {31'd0, fwd1_hit}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
